// File: rtl/lzc_pipe_tree.sv
// Pipelined leading-zero counter: 8-bit leaf LZCs merged by a binary tree behind valid/ready stages.
// Define LZC_NORM_EN to add the normalised-word output out_norm (shifter in the final stage).

module lzc_leaf (
    input  logic [7:0] d_i,
    output logic [2:0] z_o,
    output logic       v_o
);
    // Scan LSB to MSB so the highest set bit wins.
    always_comb begin
        z_o = 3'd0;
        for (int i = 0; i < 8; i++)
            if (d_i[i]) z_o = 3'(7 - i);
        v_o = (d_i == 8'd0);
    end
endmodule

module lzc_tree #(
    parameter int NL = 2,
    parameter int CW = 4
) (
    input  logic [NL-1:0][2:0] zg_i,
    input  logic [NL-1:0]      vg_i,
    output logic [CW-1:0]      cnt_o,
    output logic               zero_o
);
    localparam int LV = $clog2(NL);

    // Heap layout: node i merges 2i (upper half) and 2i+1 (lower half); leaves at NL..2NL-1.
    logic [CW-1:0] z [1:2*NL-1];
    logic          v [1:2*NL-1];

    for (genvar g = 0; g < NL; g++) begin : g_leaf
        assign z[2*NL-1-g] = CW'(zg_i[g]);
        assign v[2*NL-1-g] = vg_i[g];
    end

    for (genvar i = 1; i < NL; i++) begin : g_node
        localparam int CHW = 3 + LV - ($clog2(2*i+1) - 1);
        assign v[i] = v[2*i] & v[2*i+1];
        assign z[i] = v[2*i] ? ((CW'(1) << CHW) | z[2*i+1]) : z[2*i];
    end

    assign cnt_o  = z[1];
    assign zero_o = v[1];
endmodule

module lzc_pipe_tree #(
    parameter  int WIDTH = 16,
    parameter  int PIPE  = 2,
    parameter  int TAG_W = 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
`ifdef LZC_NORM_EN
    ,
    output logic [WIDTH-1:0] out_norm
`endif
);
    localparam int NL = WIDTH / 8;

    logic [NL-1:0][2:0] zg;
    logic [NL-1:0]      vg;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        lzc_leaf u_leaf (
            .d_i (in_data[8*g +: 8]),
            .z_o (zg[g]),
            .v_o (vg[g])
        );
    end

    logic [PIPE:1]      vld_q, vld_d;
    logic               rdy_en_q;
    logic               out_adv, in_acc;
    logic [NL-1:0][2:0] tz;
    logic [NL-1:0]      tv;
    logic [TAG_W-1:0]   ftag;
    logic               fld;
    logic [CW-1:0]      fcnt;
    logic               fzero;
    logic [CW-1:0]      cnt_q;
    logic               zero_q;
    logic [TAG_W-1:0]   otag_q;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0]   fdata;
    logic [WIDTH-1:0]   norm_q;
`endif

    // rdy_en_q holds in_ready low until the first clock after reset release.
    assign out_adv  = !vld_q[PIPE] | out_ready;
    assign in_ready = rdy_en_q & (!vld_q[1] | out_adv);
    assign in_acc   = in_valid & in_ready;

    always_comb begin
        vld_d = vld_q;
        if (in_ready) vld_d[1] = in_valid;
        if (PIPE == 2 && out_adv) vld_d[PIPE] = vld_q[1];
    end

    if (PIPE == 2) begin : g_p2
        logic [NL-1:0][2:0] zg_q;
        logic [NL-1:0]      vg_q;
        logic [TAG_W-1:0]   s1_tag_q;
`ifdef LZC_NORM_EN
        logic [WIDTH-1:0]   s1_data_q;
`endif
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                zg_q     <= '0;
                vg_q     <= '0;
                s1_tag_q <= '0;
`ifdef LZC_NORM_EN
                s1_data_q <= '0;
`endif
            end else if (in_acc) begin
                zg_q     <= zg;
                vg_q     <= vg;
                s1_tag_q <= in_tag;
`ifdef LZC_NORM_EN
                s1_data_q <= in_data;
`endif
            end
        end
        assign tz   = zg_q;
        assign tv   = vg_q;
        assign ftag = s1_tag_q;
        assign fld  = out_adv & vld_q[1];
`ifdef LZC_NORM_EN
        assign fdata = s1_data_q;
`endif
    end else begin : g_p1
        assign tz   = zg;
        assign tv   = vg;
        assign ftag = in_tag;
        assign fld  = in_acc;
`ifdef LZC_NORM_EN
        assign fdata = in_data;
`endif
    end

    lzc_tree #(.NL(NL), .CW(CW)) u_tree (
        .zg_i   (tz),
        .vg_i   (tv),
        .cnt_o  (fcnt),
        .zero_o (fzero)
    );

    // Output fields only change on a load, so they hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q    <= '0;
            rdy_en_q <= 1'b0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            otag_q   <= '0;
`ifdef LZC_NORM_EN
            norm_q   <= '0;
`endif
        end else begin
            vld_q    <= vld_d;
            rdy_en_q <= 1'b1;
            if (fld) begin
                cnt_q  <= fzero ? '0 : fcnt;
                zero_q <= fzero;
                otag_q <= ftag;
`ifdef LZC_NORM_EN
                norm_q <= fzero ? '0 : (fdata << fcnt);
`endif
            end
        end
    end

    assign out_valid = vld_q[PIPE];
    assign out_count = cnt_q;
    assign out_zero  = zero_q;
    assign out_tag   = otag_q;
`ifdef LZC_NORM_EN
    assign out_norm  = norm_q;
`endif

    a_hold: assert property (@(posedge clk) disable iff (!reset)
        out_valid && !out_ready |=> out_valid && $stable({out_count, out_zero, out_tag}));
endmodule

// File: tb/tb_lzc_pipe_tree.sv
// Scoreboard bench for lzc_pipe_tree: main 16-bit/2-stage instance plus 8/1 and 64/2 sweep instances.
module tb_lzc_pipe_tree;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_zero;
    logic [15:0] in_data = '0;
    logic [3:0]  in_tag = '0, out_tag, out_count;
    logic        a8_iv = 1'b0, a8_ir, a8_ov, a8_oz, a64_iv = 1'b0, a64_ir, a64_ov, a64_oz;
    logic        s_out_ready = 1'b1;
    logic [7:0]  a8_d = '0;
    logic [63:0] a64_d = '0;
    logic [3:0]  a8_it = '0, a8_ot, a64_it = '0, a64_ot;
    logic [2:0]  a8_oc;
    logic [5:0]  a64_oc;
`ifdef LZC_NORM_EN
    logic [15:0] out_norm;
    logic [7:0]  a8_on;
    logic [63:0] a64_on;
`endif

    lzc_pipe_tree #(.WIDTH(16), .PIPE(2), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_zero(out_zero), .out_tag(out_tag)
`ifdef LZC_NORM_EN
        , .out_norm(out_norm)
`endif
    );
    lzc_pipe_tree #(.WIDTH(8), .PIPE(1), .TAG_W(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(a8_iv), .in_ready(a8_ir),
        .in_data(a8_d), .in_tag(a8_it), .out_valid(a8_ov), .out_ready(s_out_ready),
        .out_count(a8_oc), .out_zero(a8_oz), .out_tag(a8_ot)
`ifdef LZC_NORM_EN
        , .out_norm(a8_on)
`endif
    );
    lzc_pipe_tree #(.WIDTH(64), .PIPE(2), .TAG_W(4)) dut64 (
        .clk(clk), .reset(reset), .in_valid(a64_iv), .in_ready(a64_ir),
        .in_data(a64_d), .in_tag(a64_it), .out_valid(a64_ov), .out_ready(s_out_ready),
        .out_count(a64_oc), .out_zero(a64_oz), .out_tag(a64_ot)
`ifdef LZC_NORM_EN
        , .out_norm(a64_on)
`endif
    );

    typedef struct { int cnt; bit zero; logic [3:0] tag; logic [63:0] norm; int cyc; } exp_t;
    typedef struct { logic [15:0] d; logic [3:0] t; int cnt; bit z; logic [15:0] nrm; } vec_t;

    exp_t q[$], q8[$], q64[$];
    int   checks = 0, errors = 0, cyc = 0;
    bit   lat_chk = 1'b0;
    int   npop = 0, first_pop = 0, last_pop = 0;
    logic ordy = 1'b1, s_ordy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int lz_ref(input logic [63:0] d, input int w);
        for (int b = w - 1; b >= 0; b--)
            if (d[b]) return w - 1 - b;
        return 0;
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input int w, input logic [3:0] t);
        exp_t e;
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        e.zero = (d == 64'd0);
        e.cnt  = lz_ref(d, w);
        e.tag  = t;
        e.norm = (d << e.cnt) & m;
        e.cyc  = cyc;
        return e;
    endfunction

    // All input changes happen on the falling edge; monitors sample 1 time unit later.
    task automatic tick();
        @(negedge clk);
        out_ready   = ordy;
        s_out_ready = s_ordy;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            in_valid = 1'b0;
            in_data  = 'x;
            in_tag   = 'x;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] t, input exp_t e, output int waits);
        tick();
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        #1;
        waits = 0;
        while (!in_ready && waits < 64) begin
            tick();
            #1;
            waits++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept");
        end else begin
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main_unexpected actual=out_valid count=%0d tag=%0d expected=no_output", out_count, out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("main_count", 64'(out_count), 64'(e.cnt));
                chk("main_zero", 64'(out_zero), 64'(e.zero));
                chk("main_tag", 64'(out_tag), 64'(e.tag));
`ifdef LZC_NORM_EN
                chk("main_norm", 64'(out_norm), e.norm);
`endif
                if (lat_chk) chk("main_latency", 64'(cyc - e.cyc), 64'd2);
                if (npop == 0) first_pop = cyc;
                last_pop = cyc;
                npop++;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (reset && a8_ov && s_out_ready) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8_unexpected actual=out_valid expected=no_output");
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_count", 64'(a8_oc), 64'(e.cnt));
                chk("w8_zero", 64'(a8_oz), 64'(e.zero));
                chk("w8_tag", 64'(a8_ot), 64'(e.tag));
`ifdef LZC_NORM_EN
                chk("w8_norm", 64'(a8_on), e.norm);
`endif
            end
        end
        if (reset && a64_ov && s_out_ready) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL w64_unexpected actual=out_valid expected=no_output");
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk("w64_count", 64'(a64_oc), 64'(e.cnt));
                chk("w64_zero", 64'(a64_oz), 64'(e.zero));
                chk("w64_tag", 64'(a64_ot), 64'(e.tag));
`ifdef LZC_NORM_EN
                chk("w64_norm", a64_on, e.norm);
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        logic [15:0] sd[4];
        exp_t e;
        int w, wsum, acc, k, bad, sent, guard;
        bit cap, pend;
        logic [20:0] held;
        logic [15:0] rd;
        logic [63:0] r64;

        tbl[0]  = '{16'h0001, 4'd3, 15, 1'b0, 16'h8000};
        tbl[1]  = '{16'h8000, 4'd1, 0,  1'b0, 16'h8000};
        tbl[2]  = '{16'h00FF, 4'd2, 8,  1'b0, 16'hFF00};
        tbl[3]  = '{16'h0000, 4'd4, 0,  1'b1, 16'h0000};
        tbl[4]  = '{16'h0123, 4'd5, 7,  1'b0, 16'h9180};
        tbl[5]  = '{16'h0100, 4'd6, 7,  1'b0, 16'h8000};
        tbl[6]  = '{16'h7FFF, 4'd7, 1,  1'b0, 16'hFFFE};
        tbl[7]  = '{16'h0080, 4'd8, 8,  1'b0, 16'h8000};
        tbl[8]  = '{16'h1000, 4'd9, 3,  1'b0, 16'h8000};
        tbl[9]  = '{16'h0010, 4'hA, 11, 1'b0, 16'h8000};
        tbl[10] = '{16'h0C30, 4'hB, 4,  1'b0, 16'hC300};

        // Reset state
        idle(3);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef LZC_NORM_EN
        chk("rst_out_norm", 64'(out_norm), 64'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table stream, back-to-back at full throughput with fixed latency
        lat_chk = 1'b1;
        npop = 0;
        wsum = 0;
        for (int i = 0; i < 11; i++) begin
            e.cnt = tbl[i].cnt; e.zero = tbl[i].z; e.tag = tbl[i].t;
            e.norm = 64'(tbl[i].nrm); e.cyc = 0;
            send(tbl[i].d, tbl[i].t, e, w);
            wsum += w;
        end
        idle(5);
        lat_chk = 1'b0;
        chk("tput_no_wait", 64'(wsum), 64'd0);
        chk("tput_pops", 64'(npop), 64'd11);
        chk("tput_span", 64'(last_pop - first_pop), 64'd10);

        // Output stall: two accepts fill the pipe, fields held, nothing lost on release
        sd[0] = 16'h4000; sd[1] = 16'h0003; sd[2] = 16'h0F00; sd[3] = 16'h0000;
        ordy = 1'b0; acc = 0; k = 0; cap = 1'b0; held = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            in_valid = 1'b1;
            in_data  = sd[k];
            in_tag   = 4'(k + 8);
            #1;
            if (in_ready) begin
                e = mk(64'(sd[k]), 16, 4'(k + 8));
                q.push_back(e);
                k++; acc++;
            end
            if (out_valid) begin
                if (!cap) begin
                    cap = 1'b1;
                    held = {out_count, out_zero, out_tag, 12'd0};
                end else
                    chk("stall_hold", 64'({out_count, out_zero, out_tag, 12'd0}), 64'(held));
            end
        end
        chk("stall_accepts", 64'(acc), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        ordy = 1'b1;
        while (k < 4) begin
            send(sd[k], 4'(k + 8), mk(64'(sd[k]), 16, 4'(k + 8)), w);
            k++;
        end
        idle(5);
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Reset with two words in flight
        ordy = 1'b0;
        send(16'h0002, 4'd1, mk(64'h2, 16, 4'd1), w);
        send(16'h0400, 4'd2, mk(64'h400, 16, 4'd2), w);
        tick();
        in_valid = 1'b0;
        #1;
        chk("midrst_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        q.delete();
        idle(2);
        ordy = 1'b1;
        tick();
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            tick();
            #1;
            if (out_valid) bad++;
        end
        chk("midrst_no_stale", 64'(bad), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // Random words, random backpressure, X on idle cycles
        sent = 0; guard = 0; pend = 1'b0; rd = '0;
        while (sent < 40 && guard < 2000) begin
            guard++;
            ordy = ($urandom_range(0, 3) != 0);
            tick();
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                rd = 16'($urandom() >> $urandom_range(16, 31));
                if ($urandom_range(0, 7) == 0) rd = '0;
            end
            in_valid = pend;
            in_data  = pend ? rd : 'x;
            in_tag   = pend ? 4'(sent) : 'x;
            #1;
            if (in_valid && in_ready) begin
                q.push_back(mk(64'(rd), 16, 4'(sent)));
                sent++;
                pend = 1'b0;
            end
        end
        chk("rand_sent", 64'(sent), 64'd40);
        ordy = 1'b1;
        idle(6);
        chk("rand_drained", 64'(q.size()), 64'd0);

        // One-hot sweeps and random words on the 8-bit and 64-bit instances
        for (int i = 0; i < 104; i++) begin
            s_ordy = (i < 64) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
            a8_iv = 1'b1;
            a64_iv = 1'b1;
            a8_it = 4'(i);
            a64_it = 4'(i);
            a8_d = (i < 8) ? (8'd1 << i) : 8'($urandom() >> $urandom_range(24, 31));
            r64 = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) r64 = '0;
            a64_d = (i < 64) ? (64'd1 << i) : r64;
            #1;
            if (a8_ir) begin
                e = mk(64'(a8_d), 8, 4'(i));
                if (i < 8) e.cnt = 7 - i;
                q8.push_back(e);
            end
            if (a64_ir) begin
                e = mk(a64_d, 64, 4'(i));
                if (i < 64) e.cnt = 63 - i;
                q64.push_back(e);
            end
        end
        s_ordy = 1'b1;
        tick();
        a8_iv = 1'b0;
        a64_iv = 1'b0;
        idle(6);
        chk("w8_drained", 64'(q8.size()), 64'd0);
        chk("w64_drained", 64'(q64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
